// File: rtl/vga_stream_fifo.sv
// vga_stream_fifo: parametrised single-clock show-ahead FIFO for the VGA
// pixel path. The memory fetch engine pushes words in and the pixel output
// stage pops them out.
//
// Storage is a WIDTH x 2^DEPTH_LOG2 RAM with a registered, read-enabled port.
// That port's read register acts as an in-flight stage ahead of a one-word
// output register. All DEPTH slots are usable. The occupancy count covers
// every word held in the RAM, the read stage and the output register.
//
// Ports:
//   clk_i       clock (rising edge)
//   rst_i       asynchronous active-high reset
//   data_in_i   write data
//   push_i      write request, taken when push_i & accept_o
//   pop_i       read acknowledge, taken when pop_i & valid_o
//   flush_i     synchronous discard of all contents (wins over push/pop)
//   data_out_o  head word, valid when valid_o
//   valid_o     head word present
//   accept_o    space available (level_o < DEPTH)
//   level_o     words accepted and not yet popped (0..DEPTH)
//   afull_o     level_o >= AFULL_LEVEL
//   underrun_o  sticky pop-while-empty flag
//
// Optional feature: define VGA_STREAM_FIFO_UNDERRUN_EN to build the underrun
// detector. Without it, underrun_o is tied low.
module vga_stream_fifo #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned AFULL_LEVEL = 768
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WIDTH-1:0]      data_in_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [WIDTH-1:0]      data_out_o,
  output logic                  valid_o,
  output logic                  accept_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  afull_o,
  output logic                  underrun_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned PW    = DEPTH_LOG2;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rdata_q;
  logic             rd_valid_q;
  logic [WIDTH-1:0] data_q;
  logic             out_valid_q;

  logic             push_acc;
  logic             pop_acc;
  logic             out_load;
  logic             rd_issue;
  logic [CW-1:0]    ram_cnt;

  // Handshakes and prefetch decisions
  always_comb begin
    push_acc = push_i & accept_o;
    pop_acc  = pop_i & out_valid_q;
    // Words still sitting in the RAM, not yet read out
    ram_cnt  = cnt_q - CW'(out_valid_q) - CW'(rd_valid_q);
    // Read stage moves to the output register when that register frees up
    out_load = rd_valid_q & (~out_valid_q | pop_acc);
    // Read another word only if the read stage will be free after this edge
    rd_issue = (ram_cnt != '0) & (~rd_valid_q | out_load);
  end

  assign accept_o   = (cnt_q != CW'(DEPTH));
  assign afull_o    = (cnt_q >= CW'(AFULL_LEVEL));
  assign level_o    = cnt_q;
  assign valid_o    = out_valid_q;
  assign data_out_o = data_q;

  // RAM write port. A write never targets the slot being read, because full
  // rejects pushes and a read only issues on a slot that is already written.
  always_ff @(posedge clk_i) begin
    if (push_acc && !flush_i) begin
      mem[wr_ptr_q] <= data_in_i;
    end
  end

  // RAM read port with read enable. The data holds until the next read.
  always_ff @(posedge clk_i) begin
    if (rd_issue && !flush_i) begin
      rdata_q <= mem[rd_ptr_q];
    end
  end

  // Pointers, occupancy and output stages
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rd_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
    end else if (flush_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rd_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (rd_issue) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end

      if (rd_issue) begin
        rd_valid_q <= 1'b1;
      end else if (out_load) begin
        rd_valid_q <= 1'b0;
      end

      if (out_load) begin
        data_q      <= rdata_q;
        out_valid_q <= 1'b1;
      end else if (pop_acc) begin
        out_valid_q <= 1'b0;
      end

      case ({push_acc, pop_acc})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef VGA_STREAM_FIFO_UNDERRUN_EN
  logic underrun_q;

  // Sticky flag: set by a pop with no head word, cleared only by flush/reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      underrun_q <= 1'b0;
    end else if (flush_i) begin
      underrun_q <= 1'b0;
    end else if (pop_i && !out_valid_q) begin
      underrun_q <= 1'b1;
    end
  end

  assign underrun_o = underrun_q;
`else
  assign underrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_vga_stream_fifo.sv
// Self-checking bench for vga_stream_fifo with a 16-deep, 32-bit configuration.
// Directed vectors and hand sequences run first, then a randomized stream that
// is checked against a queue-based reference model.
module tb_vga_stream_fifo;

  localparam int unsigned W     = 32;
  localparam int unsigned DL    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 12;
`ifdef VGA_STREAM_FIFO_UNDERRUN_EN
  localparam logic UND_EN = 1'b1;
`else
  localparam logic UND_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [W-1:0]  data_in;
  logic          push;
  logic          pop;
  logic          flush;
  logic [W-1:0]  data_out;
  logic          valid;
  logic          accept;
  logic [DL:0]   level;
  logic          afull;
  logic          underrun;

  vga_stream_fifo #(.WIDTH(W), .DEPTH_LOG2(DL), .AFULL_LEVEL(AF)) dut (
    .clk_i(clk), .rst_i(rst), .data_in_i(data_in), .push_i(push),
    .pop_i(pop), .flush_i(flush), .data_out_o(data_out), .valid_o(valid),
    .accept_o(accept), .level_o(level), .afull_o(afull), .underrun_o(underrun)
  );

  always #5 clk = ~clk;

  // Reference model: queue of words tagged with the edge that accepted them.
  // A head word is visible from two edges after it was pushed.
  typedef struct {
    logic [W-1:0] data;
    int           t;
  } ent_t;

  ent_t q[$];
  int   n;
  logic und_m;

  int n_cmp;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic model_valid();
    return (q.size() > 0) && (q[0].t + 2 <= n);
  endfunction

  // Apply one cycle of inputs, advance the model on the edge, then settle
  task automatic cycle(input logic pu, input logic po, input logic fl, input logic [W-1:0] d);
    logic mv;
    logic macc;
    push    = pu;
    pop     = po;
    flush   = fl;
    data_in = d;
    mv   = model_valid();
    macc = (q.size() < DEPTH);
    @(posedge clk);
    n++;
    if (fl) begin
      q.delete();
      und_m = 1'b0;
    end else begin
      if (po && !mv && UND_EN) und_m = 1'b1;
      if (po && mv) void'(q.pop_front());
      if (pu && macc) q.push_back('{data: d, t: n});
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    logic mv;
    mv = model_valid();
    chk({tag, "_valid"}, 32'(valid), 32'(mv));
    if (mv) chk({tag, "_data"}, data_out, q[0].data);
    chk({tag, "_level"}, 32'(level), 32'(q.size()));
    chk({tag, "_accept"}, 32'(accept), 32'(q.size() < DEPTH));
    chk({tag, "_afull"}, 32'(afull), 32'(q.size() >= AF));
    chk({tag, "_underrun"}, 32'(underrun), 32'(und_m));
  endtask

  typedef struct {
    logic         pu;
    logic         po;
    logic         fl;
    logic [W-1:0] d;
    logic         ev;
    logic [W-1:0] ed;
    int           el;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [W-1:0] exp_drain[16];
    int           next_val;
    int           exp_out;
    int           budget;
    logic         pu;
    logic         po;

    clk = 1'b0; rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; data_in = '0;
    n_cmp = 0; n_fail = 0; n = 0; und_m = 1'b0;

    tbl[0] = '{pu: 1, po: 0, fl: 0, d: 32'hA5A5_0001, ev: 0, ed: 0,            el: 1};
    tbl[1] = '{pu: 0, po: 0, fl: 0, d: 0,            ev: 0, ed: 0,            el: 1};
    tbl[2] = '{pu: 0, po: 0, fl: 0, d: 0,            ev: 1, ed: 32'hA5A5_0001, el: 1};
    tbl[3] = '{pu: 0, po: 1, fl: 0, d: 0,            ev: 0, ed: 0,            el: 0};
    tbl[4] = '{pu: 1, po: 0, fl: 0, d: 32'h11,       ev: 0, ed: 0,            el: 1};
    tbl[5] = '{pu: 1, po: 0, fl: 0, d: 32'h22,       ev: 0, ed: 0,            el: 2};
    tbl[6] = '{pu: 0, po: 0, fl: 0, d: 0,            ev: 1, ed: 32'h11,       el: 2};
    tbl[7] = '{pu: 0, po: 1, fl: 0, d: 0,            ev: 1, ed: 32'h22,       el: 1};
    tbl[8] = '{pu: 0, po: 1, fl: 0, d: 0,            ev: 0, ed: 0,            el: 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_data", data_out, 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_accept", 32'(accept), 1);
    chk("rst_afull", 32'(afull), 0);
    chk("rst_underrun", 32'(underrun), 0);
    rst = 1'b0;

    // Directed vectors: latency, show-ahead and streaming basics
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].pu, tbl[i].po, tbl[i].fl, tbl[i].d);
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("vec%0d_data", i), data_out, tbl[i].ed);
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].el));
      chk($sformatf("vec%0d_accept", i), 32'(accept), 1);
      chk($sformatf("vec%0d_afull", i), 32'(afull), 0);
    end

    // Fill to full, watching almost-full and accept
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'(i));
      chk($sformatf("fill%0d_level", i), 32'(level), 32'(i + 1));
      chk($sformatf("fill%0d_afull", i), 32'(afull), 32'((i + 1) >= 12));
      chk($sformatf("fill%0d_accept", i), 32'(accept), 32'((i + 1) < 16));
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h99);
    chk("over_level", 32'(level), 16);
    chk("over_accept", 32'(accept), 0);
    chk("full_head_valid", 32'(valid), 1);
    chk("full_head_data", data_out, 0);

    // Push and pop together when full: pop wins, push dropped
    cycle(1'b1, 1'b1, 1'b0, 32'h55);
    chk("pp_full_level", 32'(level), 15);
    chk("pp_full_data", data_out, 1);
    cycle(1'b1, 1'b0, 1'b0, 32'h100);
    chk("refill_level", 32'(level), 16);

    // Back-to-back drain in order with valid continuously high
    for (int i = 0; i < 15; i++) exp_drain[i] = 32'(i + 1);
    exp_drain[15] = 32'h100;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_valid", i), 32'(valid), 1);
      chk($sformatf("drain%0d_data", i), data_out, exp_drain[i]);
      cycle(1'b0, 1'b1, 1'b0, '0);
    end
    chk("drain_level", 32'(level), 0);
    chk("drain_valid", 32'(valid), 0);

    // Flush overrides push and pop in the same cycle
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'hF0 + 32'(i));
    cycle(1'b1, 1'b1, 1'b1, 32'hEE);
    chk("flush_level", 32'(level), 0);
    chk("flush_valid", 32'(valid), 0);
    cycle(1'b1, 1'b0, 1'b0, 32'h77);
    chk("post_flush_level", 32'(level), 1);
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    chk("post_flush_valid", 32'(valid), 1);
    chk("post_flush_data", data_out, 32'h77);
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("post_flush_pop_level", 32'(level), 0);

    // Underrun: set by pop while empty, sticky, cleared by flush
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("und_set", 32'(underrun), 32'(UND_EN));
    cycle(1'b1, 1'b0, 1'b0, 32'h5);
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("und_hold", 32'(underrun), 32'(UND_EN));
    cycle(1'b0, 1'b0, 1'b1, '0);
    chk("und_flush", 32'(underrun), 0);
    check_model("pre_rand");

    // Randomized stream of 3*DEPTH incrementing words across pointer wraps
    next_val = 0;
    exp_out  = 0;
    budget   = 0;
    while (exp_out < 3 * DEPTH && budget < 3000) begin
      pu = (next_val < 3 * DEPTH) && ($urandom_range(0, 2) != 0);
      po = ($urandom_range(0, 1) != 0);
      if (po && valid) begin
        chk($sformatf("rand_order%0d", exp_out), data_out, 32'h1000 + 32'(exp_out));
        exp_out++;
      end
      cycle(pu, po, 1'b0, 32'h1000 + 32'(next_val));
      if (pu && q.size() > 0 && q[q.size()-1].t == n) next_val++;
      check_model($sformatf("rand%0d", budget));
      budget++;
    end
    chk("rand_all_drained", 32'(exp_out), 32'(3 * DEPTH));

    // Asynchronous reset in the middle of a transfer
    cycle(1'b1, 1'b0, 1'b0, 32'hAB);
    cycle(1'b1, 1'b0, 1'b0, 32'hCD);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(valid), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_accept", 32'(accept), 1);
    chk("arst_data", data_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    und_m = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 32'h3C);
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check_model("post_arst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
